// File: rtl/fpu_dispatch.sv
// Dispatches F-type instructions: retires sign-inject/move ops directly and
// hands every other op to one of NUNIT FPU units, waiting for its result.
module fpu_dispatch #(
    parameter int NUNIT = 4,
    parameter int TMO_W = 8,
    localparam int UW = (NUNIT > 1) ? $clog2(NUNIT) : 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             indecode,
    input  logic [6:0]       op,
    input  logic [6:0]       funct7,
    input  logic [UW-1:0]    unit_sel,
    input  logic             fregwb,
    input  logic [NUNIT-1:0] fpu_valid,
    input  logic             flush,
    input  logic             err_clr,
    output logic             fregwrite_f,
    output logic             regwrite_f,
    output logic [1:0]       fregsrc_f,
    output logic [2:0]       regsrc_f,
    output logic             flpt_done,
    output logic [NUNIT-1:0] fpu_go,
    output logic             busy,
    output logic             tmo_err,
    output logic [3:0]       o_dbg_state
);

    localparam logic [6:0] OP_FTYPE = 7'b1010011;
    localparam logic [6:0] F7_SGNJN = 7'b0010000;
    localparam logic [6:0] F7_MVXW  = 7'b1110000;
    localparam logic [6:0] F7_MVWX  = 7'b1111000;

    // Last WAIT cycle: the counter reaches TMO_MAX on this edge.
    localparam logic [TMO_W-1:0] CNT_LAST = {{(TMO_W-1){1'b1}}, 1'b0};
    localparam logic [UW:0]      NUNIT_L  = NUNIT[UW:0];

    typedef enum logic [3:0] {
        IDLE    = 4'd0,
        SGNJ_EX = 4'd1,
        MVXW_EX = 4'd2,
        MVWX_EX = 4'd3,
        GO      = 4'd4,
        WAIT    = 4'd5,
        IREG_WB = 4'd6,
        FREG_WB = 4'd7,
        TMO     = 4'd8
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [UW-1:0]      r_unit;
    logic               r_wb;
    logic [TMO_W-1:0]   r_cnt;
    logic               r_tmo_err;
    logic               w_ok;
    logic               w_unit_ok;
    logic [NUNIT-1:0]   w_onehot;
    logic               w_valid;

    assign w_ok      = indecode && (op == OP_FTYPE);
    assign w_unit_ok = ({1'b0, r_unit} < NUNIT_L);

    // An out-of-range latched unit yields an all-zero one-hot.
    always_comb begin
        w_onehot = '0;
        for (int i = 0; i < NUNIT; i++) begin
            w_onehot[i] = (r_unit == UW'(i));
        end
    end

    assign w_valid = |(fpu_valid & w_onehot);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_ok) begin
                    case (funct7)
                        F7_SGNJN: w_next = SGNJ_EX;
                        F7_MVXW:  w_next = MVXW_EX;
                        F7_MVWX:  w_next = MVWX_EX;
                        default:  w_next = GO;
                    endcase
                end
            end
            GO: begin
                if (flush)           w_next = IDLE;
                else if (!w_unit_ok) w_next = TMO;
                else                 w_next = WAIT;
            end
            WAIT: begin
                if (flush)                  w_next = IDLE;
                else if (w_valid)           w_next = r_wb ? IREG_WB : FREG_WB;
                else if (r_cnt == CNT_LAST) w_next = TMO;
                else                        w_next = WAIT;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_unit    <= '0;
            r_wb      <= 1'b0;
            r_cnt     <= '0;
            r_tmo_err <= 1'b0;
        end else begin
            if (r_state == IDLE && w_next == GO) begin
                r_unit <= unit_sel;
                r_wb   <= fregwb;
            end
            if (r_state == GO) begin
                r_cnt <= '0;
            end else if (r_state == WAIT) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_next == TMO) begin
                r_tmo_err <= 1'b1;
            end else if (err_clr) begin
                r_tmo_err <= 1'b0;
            end
        end
    end

    always_comb begin
        fregwrite_f = 1'b0;
        regwrite_f  = 1'b0;
        fregsrc_f   = 2'b00;
        regsrc_f    = 3'b000;
        flpt_done   = 1'b0;
        fpu_go      = '0;
        case (r_state)
            SGNJ_EX: begin
                fregwrite_f = 1'b1;
                fregsrc_f   = 2'b01;
                flpt_done   = 1'b1;
            end
            MVXW_EX: begin
                regwrite_f = 1'b1;
                regsrc_f   = 3'b101;
                flpt_done  = 1'b1;
            end
            MVWX_EX: begin
                fregwrite_f = 1'b1;
                fregsrc_f   = 2'b10;
                flpt_done   = 1'b1;
            end
            GO: fpu_go = w_onehot;
            IREG_WB: begin
                regwrite_f = 1'b1;
                regsrc_f   = 3'b110;
                flpt_done  = 1'b1;
            end
            FREG_WB: begin
                fregwrite_f = 1'b1;
                fregsrc_f   = 2'b11;
                flpt_done   = 1'b1;
            end
            TMO: flpt_done = 1'b1;
            default: ;
        endcase
    end

    assign busy        = (r_state != IDLE);
    assign tmo_err     = r_tmo_err;
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_fpu_dispatch.sv
// Bench for fpu_dispatch (NUNIT=4, TMO_W=4): directed scenarios with literal
// expectations, then random stimulus checked every cycle against a model.
module tb_fpu_dispatch;

    localparam int NUNIT = 4;
    localparam int TMO_W = 4;
    localparam int TMO_MAX = (1 << TMO_W) - 1;
    localparam logic [6:0] FTYPE = 7'b1010011;
    localparam logic [6:0] SGNJN = 7'b0010000;
    localparam logic [6:0] MVXW  = 7'b1110000;
    localparam logic [6:0] MVWX  = 7'b1111000;

    // {fregwrite_f, regwrite_f, fregsrc_f, regsrc_f, flpt_done}
    localparam logic [7:0] V_SGNJ = 8'b1_0_01_000_1;
    localparam logic [7:0] V_MVXW = 8'b0_1_00_101_1;
    localparam logic [7:0] V_MVWX = 8'b1_0_10_000_1;
    localparam logic [7:0] V_IREG = 8'b0_1_00_110_1;
    localparam logic [7:0] V_FREG = 8'b1_0_11_000_1;
    localparam logic [7:0] V_TMO  = 8'b0_0_00_000_1;

    logic             clk = 1'b0;
    logic             rstn;
    logic             indecode;
    logic [6:0]       op;
    logic [6:0]       funct7;
    logic [1:0]       unit_sel;
    logic             fregwb;
    logic [NUNIT-1:0] fpu_valid;
    logic             flush;
    logic             err_clr;
    logic             fregwrite_f;
    logic             regwrite_f;
    logic [1:0]       fregsrc_f;
    logic [2:0]       regsrc_f;
    logic             flpt_done;
    logic [NUNIT-1:0] fpu_go;
    logic             busy;
    logic             tmo_err;
    logic [3:0]       dbg_state;

    int n_vec = 0;
    int n_err = 0;

    fpu_dispatch #(.NUNIT(NUNIT), .TMO_W(TMO_W)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .indecode    (indecode),
        .op          (op),
        .funct7      (funct7),
        .unit_sel    (unit_sel),
        .fregwb      (fregwb),
        .fpu_valid   (fpu_valid),
        .flush       (flush),
        .err_clr     (err_clr),
        .fregwrite_f (fregwrite_f),
        .regwrite_f  (regwrite_f),
        .fregsrc_f   (fregsrc_f),
        .regsrc_f    (regsrc_f),
        .flpt_done   (flpt_done),
        .fpu_go      (fpu_go),
        .busy        (busy),
        .tmo_err     (tmo_err),
        .o_dbg_state (dbg_state)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [7:0] outs();
        return {fregwrite_f, regwrite_f, fregsrc_f, regsrc_f, flpt_done};
    endfunction

    // Model: phase 0 idle, 1 go, 2 waiting, 3 retiring (with m_out pattern).
    int         m_ph;
    int         m_unit;
    bit         m_wb;
    int         m_waited;
    bit         m_err;
    logic [7:0] m_out;

    task automatic model_step();
        bit ok;
        bit to_tmo;
        int nph;
        ok = indecode && (op == FTYPE);
        to_tmo = 1'b0;
        nph = m_ph;
        case (m_ph)
            0: if (ok) begin
                if (funct7 == SGNJN)     begin nph = 3; m_out = V_SGNJ; end
                else if (funct7 == MVXW) begin nph = 3; m_out = V_MVXW; end
                else if (funct7 == MVWX) begin nph = 3; m_out = V_MVWX; end
                else begin nph = 1; m_unit = int'(unit_sel); m_wb = fregwb; end
            end
            1: begin
                if (flush) nph = 0;
                else if (m_unit >= NUNIT) begin nph = 3; m_out = V_TMO; to_tmo = 1'b1; end
                else begin nph = 2; m_waited = 0; end
            end
            2: begin
                if (flush) nph = 0;
                else if (fpu_valid[m_unit]) begin nph = 3; m_out = m_wb ? V_IREG : V_FREG; end
                else begin
                    m_waited++;
                    if (m_waited == TMO_MAX) begin nph = 3; m_out = V_TMO; to_tmo = 1'b1; end
                end
            end
            default: nph = 0;
        endcase
        if (to_tmo) m_err = 1'b1;
        else if (err_clr) m_err = 1'b0;
        m_ph = nph;
    endtask

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            m_ph = 0; m_unit = 0; m_wb = 0; m_waited = 0; m_err = 0; m_out = '0;
        end else begin
            model_step();
        end
        #1;
        check("outs", {8'h0, outs()}, {8'h0, (m_ph == 3) ? m_out : 8'h00});
        check("fpu_go", {12'h0, fpu_go}, {12'h0, (m_ph == 1) ? 4'(1 << m_unit) : 4'h0});
        check("busy", {15'h0, busy}, {15'h0, m_ph != 0});
        check("tmo_err", {15'h0, tmo_err}, {15'h0, m_err});
    end

    task automatic idle_inputs();
        indecode = 0; op = '0; funct7 = '0; unit_sel = '0; fregwb = 0;
        fpu_valid = '0; flush = 0; err_clr = 0;
    endtask

    // Presents an F-type op for one cycle; returns just after the GO/EX edge.
    task automatic issue(input logic [6:0] f7, input logic [1:0] u, input logic wb);
        @(negedge clk);
        indecode = 1; op = FTYPE; funct7 = f7; unit_sel = u; fregwb = wb;
        @(posedge clk); #2;
    endtask

    initial begin
        rstn = 0;
        idle_inputs();
        repeat (3) @(posedge clk);
        #2;
        check("reset_state", {outs(), fpu_go, busy, tmo_err, 2'b00}, 16'h0000);
        @(negedge clk) rstn = 1;

        // FMV.X.W retires on the next cycle, then the block is idle
        issue(MVXW, 2'd0, 1'b0);
        check("mvxw_out", {8'h0, outs()}, {8'h0, V_MVXW});
        @(negedge clk) idle_inputs();
        @(posedge clk); #2;
        check("mvxw_busy", {15'h0, busy}, 16'h0000);

        // unit 2 to FP register; input changes after latch must not matter
        issue(7'h00, 2'd2, 1'b0);
        check("go_unit2", {12'h0, fpu_go}, 16'h0004);
        @(negedge clk); idle_inputs(); unit_sel = 2'd1; fregwb = 1;
        repeat (4) @(negedge clk);
        fpu_valid = 4'b0100;
        @(posedge clk); #2;
        check("freg_wb", {8'h0, outs()}, {8'h0, V_FREG});
        @(negedge clk) idle_inputs();

        // other units' valid ignored, then own valid to integer register
        issue(7'h55, 2'd2, 1'b1);
        @(negedge clk) idle_inputs();
        @(negedge clk) fpu_valid = 4'b1011;
        @(posedge clk); #2;
        check("ignore_other_busy", {15'h0, busy}, 16'h0001);
        check("ignore_other_out", {8'h0, outs()}, 16'h0000);
        @(negedge clk) fpu_valid = 4'b0100;
        @(posedge clk); #2;
        check("ireg_wb", {8'h0, outs()}, {8'h0, V_IREG});
        @(negedge clk) idle_inputs();

        // 15 WAIT cycles without valid -> timeout, sticky error until cleared
        issue(7'h01, 2'd1, 1'b0);
        @(negedge clk) idle_inputs();
        repeat (TMO_MAX + 1) @(posedge clk);
        #2;
        check("tmo_out", {8'h0, outs()}, {8'h0, V_TMO});
        check("tmo_err_set", {15'h0, tmo_err}, 16'h0001);
        @(posedge clk); #2;
        check("tmo_idle", {15'h0, busy}, 16'h0000);
        check("tmo_err_held", {15'h0, tmo_err}, 16'h0001);
        @(negedge clk) err_clr = 1;
        @(posedge clk); #2;
        check("tmo_err_clr", {15'h0, tmo_err}, 16'h0000);
        @(negedge clk) err_clr = 0;

        // valid in the 15th WAIT cycle beats the timeout
        issue(7'h02, 2'd3, 1'b0);
        @(negedge clk) idle_inputs();
        repeat (TMO_MAX) @(posedge clk);
        @(negedge clk) fpu_valid = 4'b1000;
        @(posedge clk); #2;
        check("late_valid_wb", {8'h0, outs()}, {8'h0, V_FREG});
        check("late_valid_noerr", {15'h0, tmo_err}, 16'h0000);
        @(negedge clk) idle_inputs();

        // flush in 3rd WAIT cycle overrides a simultaneous valid
        issue(7'h03, 2'd0, 1'b1);
        @(negedge clk) idle_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk); flush = 1; fpu_valid = 4'b0001;
        @(posedge clk); #2;
        check("flush_idle", {15'h0, busy}, 16'h0000);
        check("flush_nodone", {8'h0, outs()}, 16'h0000);
        @(negedge clk) idle_inputs();

        // reset in WAIT: outputs drop without a clock edge
        issue(7'h04, 2'd1, 1'b0);
        @(negedge clk) idle_inputs();
        repeat (2) @(posedge clk);
        #3 rstn = 0;
        #1;
        check("async_reset", {outs(), fpu_go, busy, tmo_err, 2'b00}, 16'h0000);
        @(negedge clk) fpu_valid = 4'b0010;
        @(negedge clk) rstn = 1;
        @(posedge clk); #2;
        check("post_reset_valid", {7'h0, busy, outs()}, 16'h0000);
        @(negedge clk) idle_inputs();

        // SGNJ and FMV.W.X retirement patterns
        issue(SGNJN, 2'd0, 1'b0);
        check("sgnj_out", {8'h0, outs()}, {8'h0, V_SGNJ});
        @(negedge clk) idle_inputs();
        issue(MVWX, 2'd0, 1'b0);
        check("mvwx_out", {8'h0, outs()}, {8'h0, V_MVWX});
        @(negedge clk) idle_inputs();

        // random traffic
        repeat (600) begin
            @(negedge clk);
            indecode = ($urandom_range(0, 1) == 1);
            op = ($urandom_range(0, 9) < 8) ? FTYPE : 7'($urandom_range(0, 127));
            case ($urandom_range(0, 5))
                0: funct7 = SGNJN;
                1: funct7 = MVXW;
                2: funct7 = MVWX;
                default: funct7 = 7'($urandom_range(0, 127));
            endcase
            unit_sel = 2'($urandom_range(0, 3));
            fregwb = 1'($urandom_range(0, 1));
            for (int i = 0; i < NUNIT; i++) fpu_valid[i] = ($urandom_range(0, 5) == 0);
            flush = ($urandom_range(0, 24) == 0);
            err_clr = ($urandom_range(0, 7) == 0);
        end
        @(negedge clk) idle_inputs();
        repeat (3) @(posedge clk);
        #3;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fpu_dispatch.md
FPU_DISPATCH -- requirements
Module: fpu_dispatch

Interface
REQ-001 Parameter NUNIT, default 4: number of attached FPU units; legal range 2..16.
REQ-002 Parameter TMO_W, default 8: width of the wait-timeout counter; timeout limit TMO_MAX = 2^TMO_W - 1 cycles.
REQ-003 Port clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port rstn  input  1  reset, asynchronous, active-low.
REQ-005 Port indecode  input  1  core is in decode; instruction fields are valid.
REQ-006 Port op  input  7  opcode; F-type = 7'b1010011.
REQ-007 Port funct7  input  7  FSGNJN = 7'b0010000, FMV.X.W = 7'b1110000, FMV.W.X = 7'b1111000; any other value is an FPU-unit op.
REQ-008 Port unit_sel  input  clog2(NUNIT)  target unit index for FPU-unit ops.
REQ-009 Port fregwb  input  1  1 = result goes to integer register, 0 = result goes to FP register.
REQ-010 Port fpu_valid  input  NUNIT  per-unit result-valid pulse.
REQ-011 Port flush  input  1  abort the in-flight FPU-unit op.
REQ-012 Port err_clr  input  1  clears the sticky timeout flag.
REQ-013 Ports fregwrite_f, regwrite_f  output  1 each  FP / integer register write enables.
REQ-014 Ports fregsrc_f  output  2, regsrc_f  output  3  writeback source selects.
REQ-015 Port flpt_done  output  1  instruction retired (one-cycle pulse).
REQ-016 Port fpu_go  output  NUNIT  one-hot start pulse to the selected unit.
REQ-017 Port busy  output  1  high in every state except IDLE.
REQ-018 Port tmo_err  output  1  sticky timeout flag.

Function
REQ-019 ok SHALL be defined as indecode AND (op == F-type); the FSM SHALL leave IDLE only when ok is 1.
REQ-020 The FSM states SHALL be IDLE, SGNJ_EX, MVXW_EX, MVWX_EX, GO, WAIT, IREG_WB, FREG_WB, TMO.
REQ-021 IDLE with ok: funct7 FSGNJN -> SGNJ_EX; FMV.X.W -> MVXW_EX; FMV.W.X -> MVWX_EX; otherwise -> GO. Without ok the FSM SHALL remain in IDLE.
REQ-022 On the IDLE->GO transition, unit_sel and fregwb SHALL be latched; later changes on these inputs SHALL have no effect on the op.
REQ-023 If unit_sel >= NUNIT when the op is latched, the op SHALL be treated as an immediate timeout: GO -> TMO, with no fpu_go bit asserted.
REQ-024 GO SHALL assert fpu_go[latched unit] for exactly one cycle and then go to WAIT (latency from decode to go: 1 cycle).
REQ-025 WAIT: if fpu_valid[latched unit] = 1 -> IREG_WB when latched fregwb = 1, else -> FREG_WB. Valid bits of other units SHALL be ignored.
REQ-026 A wait counter SHALL clear on entry to WAIT and increment each WAIT cycle; when it equals TMO_MAX with no valid -> TMO. A valid arriving in the same cycle SHALL win over the timeout.
REQ-027 flush in GO or WAIT SHALL force IDLE on the next edge, with no write and no flpt_done. flush SHALL override both valid and timeout, and SHALL be ignored in all other states.
REQ-028 The single-cycle states, IREG_WB, FREG_WB and TMO SHALL all return to IDLE after one cycle.
REQ-029 Output vector {fregwrite_f, regwrite_f, fregsrc_f, regsrc_f, flpt_done} per state:
  - IDLE, GO, WAIT: 0_0_00_000_0
  - SGNJ_EX: 1_0_01_000_1
  - MVXW_EX: 0_1_00_101_1
  - MVWX_EX: 1_0_10_000_1
  - IREG_WB: 0_1_00_110_1
  - FREG_WB: 1_0_11_000_1
  - TMO: 0_0_00_000_1
REQ-030 tmo_err SHALL be set on entry to TMO and cleared by err_clr. If both happen in the same cycle, set SHALL win.
REQ-031 All outputs SHALL be decoded from registered state only; no combinational path from any input to any output.

Reset
REQ-032 While rstn = 0: state = IDLE, latches and wait counter = 0, tmo_err = 0, all outputs = 0; this SHALL take effect immediately, without a clock edge.
REQ-033 rstn asserted mid-operation (GO or WAIT) SHALL abandon the op; a fpu_valid arriving after release SHALL be ignored while in IDLE.

Verification
REQ-034 ok with funct7 = 7'b1110000 -> next cycle regwrite_f = 1, regsrc_f = 101, flpt_done = 1; the cycle after, busy = 0.
REQ-035 NUNIT = 4, unit_sel = 2, fregwb = 0, with fpu_valid[2] 5 cycles after go -> fpu_go = 4'b0100 for 1 cycle, then FREG_WB (fregsrc_f = 11, fregwrite_f = 1, done = 1).
REQ-036 In WAIT, fpu_valid = 4'b1011 while the latched unit is 2 -> remains in WAIT; later fpu_valid[2] -> IREG_WB if latched fregwb = 1.
REQ-037 TMO_W = 4, no valid -> after 15 WAIT cycles TMO: done = 1, no writes, tmo_err = 1 held until err_clr; valid arriving on cycle 15 -> writeback, no error.
REQ-038 flush on the 3rd WAIT cycle -> IDLE, no done; rstn dropped in WAIT -> all outputs 0 asynchronously.
